// File: rtl/note_sched_pkg.sv
// Shared constants and types for the note highway scheduler: screen limits,
// lane x-bounds, FSM states and the per-slot record.
package note_sched_pkg;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;

  localparam logic [9:0] LANE0_X0 = 10'd4;
  localparam logic [9:0] LANE0_X1 = 10'd211;
  localparam logic [9:0] LANE1_X0 = 10'd217;
  localparam logic [9:0] LANE1_X1 = 10'd423;
  localparam logic [9:0] LANE2_X0 = 10'd428;
  localparam logic [9:0] LANE2_X1 = 10'd635;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAYING,
    ST_PAUSED
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] lane;
    logic [9:0] y;
  } slot_t;

  // Lane 3 is never stored, so it simply draws nothing.
  function automatic logic in_lane(input logic [1:0] lane, input logic [9:0] h);
    case (lane)
      2'd0:    return (h >= LANE0_X0) && (h <= LANE0_X1);
      2'd1:    return (h >= LANE1_X0) && (h <= LANE1_X1);
      2'd2:    return (h >= LANE2_X0) && (h <= LANE2_X1);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/note_slot.sv
// One falling-note slot: holds valid/lane/y, advances on frame ticks, frees
// itself on hit or when it falls off screen, and reports window/pixel overlap.
module note_slot
  import note_sched_pkg::*;
#(
  parameter int NOTE_H  = 16,
  parameter int SPEED   = 4,
  parameter int HIT_Y   = 380,
  parameter int HIT_TOL = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [1:0] load_lane,
  input  logic       advance,
  input  logic       hit,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  output logic       valid,
  output logic [1:0] lane,
  output logic       in_window,
  output logic       pix_on,
  output logic       miss
);

  localparam logic [10:0] WIN_LO  = 11'(HIT_Y - HIT_TOL);
  localparam logic [10:0] WIN_HI  = 11'(HIT_Y + HIT_TOL);
  localparam logic [10:0] SPAN    = 11'(NOTE_H - 1);
  localparam logic [10:0] STEP    = 11'(SPEED);
  localparam logic [10:0] Y_LIMIT = {1'b0, SCREEN_H};

  slot_t       slot;
  logic [10:0] y_top, y_bot, y_adv;

  // 11-bit arithmetic so y + span/step can never wrap.
  assign y_top = {1'b0, slot.y};
  assign y_bot = y_top + SPAN;
  assign y_adv = y_top + STEP;

  assign valid     = slot.valid;
  assign lane      = slot.lane;
  assign in_window = slot.valid && (y_top <= WIN_HI) && (y_bot >= WIN_LO);
  assign pix_on    = slot.valid && ({1'b0, v_count} >= y_top)
                     && ({1'b0, v_count} <= y_bot) && in_lane(slot.lane, h_count);
  assign miss      = advance && slot.valid && !hit && (y_adv >= Y_LIMIT);

  // NOTE: slot registers are reset explicitly; an unreset valid bit would
  // draw and score phantom notes after power-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (clear) begin
      slot <= '0;
    end else if (hit) begin
      slot.valid <= 1'b0;
    end else if (advance && slot.valid) begin
      if (y_adv >= Y_LIMIT) slot.valid <= 1'b0;
      else                  slot.y     <= y_adv[9:0];
    end else if (load) begin
      slot <= '{valid: 1'b1, lane: load_lane, y: '0};
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Note highway controller: spawn/advance/hit/miss over a pool of note slots
// and a registered per-pixel note_visible. NOTE_SCHED_MISS_PENALTY_EN makes misses cost score.
module note_scheduler
  import note_sched_pkg::*;
#(
  parameter int SLOTS   = 8,
  parameter int NOTE_H  = 16,
  parameter int SPEED   = 4,
  parameter int HIT_Y   = 380,
  parameter int HIT_TOL = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        frame_tick,
  input  logic        spawn_valid,
  input  logic [1:0]  spawn_lane,
  output logic        spawn_ready,
  input  logic [2:0]  btn,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  output logic        note_visible,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [15:0] score,
  output logic        playing
);

  state_t state, state_next;
  logic       start_q, start_edge;
  logic [2:0] btn_q, btn_edge;
  logic       clear, advance, spawn_fire;

  logic [SLOTS-1:0] valid, in_window, pix_on, miss, hit_sel, load_sel;
  logic [1:0]       lane [SLOTS];
  logic [2:0]       lane_found;
  logic [1:0]       hit_cnt;
  int               score_sum;
  logic [15:0]      score_next;

  // NOTE: the start edge is registered, so the FSM reacts one cycle after the
  // edge register sees it; buttons use the combinational edge directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q    <= 1'b0;
      start_edge <= 1'b0;
      btn_q      <= '0;
      state      <= ST_IDLE;
    end else begin
      start_q    <= start;
      start_edge <= start && !start_q;
      btn_q      <= btn;
      state      <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (start_edge) begin
      case (state)
        ST_IDLE:    state_next = ST_PLAYING;
        ST_PLAYING: state_next = ST_PAUSED;
        ST_PAUSED:  state_next = ST_PLAYING;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  assign playing     = (state == ST_PLAYING);
  assign btn_edge    = btn & ~btn_q;
  assign clear       = (state == ST_IDLE) && start_edge;
  assign advance     = playing && frame_tick;
  assign spawn_ready = playing && !(&valid) && !frame_tick;
  assign spawn_fire  = spawn_valid && spawn_ready && (spawn_lane != 2'd3);

  // Lowest-index free slot takes the next spawn.
  always_comb begin
    load_sel = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid[i]) load_sel = SLOTS'(1) << i;
    end
  end

  // Per lane, the lowest-index slot inside the hit window is the one struck.
  always_comb begin
    hit_sel    = '0;
    hit_cnt    = '0;
    lane_found = '0;
    if (playing) begin
      for (int l = 0; l < 3; l++) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (btn_edge[l] && !lane_found[l] && in_window[i] && (lane[i] == 2'(l))) begin
            hit_sel[i]    = 1'b1;
            lane_found[l] = 1'b1;
            hit_cnt       = hit_cnt + 2'd1;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    note_slot #(
      .NOTE_H (NOTE_H),
      .SPEED  (SPEED),
      .HIT_Y  (HIT_Y),
      .HIT_TOL(HIT_TOL)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .load     (spawn_fire && load_sel[i]),
      .load_lane(spawn_lane),
      .advance  (advance),
      .hit      (hit_sel[i]),
      .h_count  (h_count),
      .v_count  (v_count),
      .valid    (valid[i]),
      .lane     (lane[i]),
      .in_window(in_window[i]),
      .pix_on   (pix_on[i]),
      .miss     (miss[i])
    );
  end

`ifdef NOTE_SCHED_MISS_PENALTY_EN
  int miss_cnt;

  always_comb begin
    miss_cnt = 0;
    for (int i = 0; i < SLOTS; i++) miss_cnt = miss_cnt + (miss[i] ? 1 : 0);
  end

  // Hits and misses of the same cycle net before saturating at either end.
  always_comb begin
    score_sum = int'(score) + int'(hit_cnt) - miss_cnt;
    if (score_sum < 0)          score_next = 16'h0000;
    else if (score_sum > 65535) score_next = 16'hFFFF;
    else                        score_next = 16'(score_sum);
  end
`else
  always_comb begin
    score_sum = int'(score) + int'(hit_cnt);
    if (score_sum > 65535) score_next = 16'hFFFF;
    else                   score_next = 16'(score_sum);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score        <= '0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      note_visible <= 1'b0;
    end else begin
      score        <= clear ? 16'h0000 : score_next;
      hit_pulse    <= |hit_sel;
      miss_pulse   <= |miss;
      note_visible <= (h_count < SCREEN_W) && (v_count < SCREEN_H) && (|pix_on);
    end
  end

endmodule
